sync_track: RTL and testbench

SYNC_TRACK -- requirements
Module: sync_track

---
 rtl/sync_track.sv | 130 +++++++++++++
 tb/tb_sync_track.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_track.sv
// sync_track: theta/epsilon lock tracker with 4-tap epsilon averaging and a 4-entry output FIFO
module sync_track #(
  parameter int THETA_W  = 8,
  parameter int EPS_W    = 12,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               est_valid,
  input  logic [THETA_W-1:0] theta_in,
  input  logic [EPS_W-1:0]   eps_in,
  input  logic               trk_ready,
  output logic               trk_valid,
  output logic [THETA_W-1:0] trk_theta,
  output logic [EPS_W-1:0]   trk_eps,
  output logic               lock,
  output logic               overflow
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  localparam logic [THETA_W-1:0] TOL_T = THETA_W'(TOL);
  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_C = 4'(MISS_MAX);
  state_t state_q, state_d;
  logic [THETA_W-1:0] ref_q, ref_d, diff, ndiff;
  logic [3:0] match_q, match_d, miss_q, miss_d;
  logic [EPS_W-1:0] hist_q [4];
  logic [EPS_W-1:0] hist_d [4];
  logic [THETA_W-1:0] fth_q [4];
  logic [THETA_W-1:0] fth_d [4];
  logic [EPS_W-1:0] feps_q [4];
  logic [EPS_W-1:0] feps_d [4];
  logic [1:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic match, pop, push, wr_en;
  logic signed [EPS_W+1:0] sum;
  logic [EPS_W-1:0] avg;
  assign diff = theta_in - ref_q;
  assign ndiff = ref_q - theta_in;
  assign match = (diff <= TOL_T) || (ndiff <= TOL_T);
  assign sum = $signed({{2{eps_in[EPS_W-1]}}, eps_in}) + $signed({{2{hist_q[0][EPS_W-1]}}, hist_q[0]})
             + $signed({{2{hist_q[1][EPS_W-1]}}, hist_q[1]}) + $signed({{2{hist_q[2][EPS_W-1]}}, hist_q[2]});
  assign avg = sum[EPS_W+1:2];
  assign pop = (cnt_q != 3'd0) && trk_ready;
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    match_d = match_q;
    miss_d = miss_q;
    hist_d = hist_q;
    push = 1'b0;
    if (est_valid) begin
      if (state_q == LOCKED) begin
        if (match) begin
          ref_d = theta_in;
          hist_d = '{eps_in, hist_q[0], hist_q[1], hist_q[2]};
          miss_d = 4'd0;
          push = 1'b1;
        end else begin
          miss_d = miss_q + 4'd1;
          if (miss_d == MISS_C) begin
            state_d = SEARCH;
            hist_d = '{default: '0};
          end
        end
      end else if (state_q == VERIFY && match) begin
        ref_d = theta_in;
        hist_d = '{eps_in, hist_q[0], hist_q[1], hist_q[2]};
        match_d = match_q + 4'd1;
        if (match_d == LOCK_C) begin
          state_d = LOCKED;
          miss_d = 4'd0;
          push = 1'b1;
        end
      end else begin
        ref_d = theta_in;
        hist_d = '{eps_in, '0, '0, '0};
        match_d = 4'd1;
        state_d = VERIFY;
      end
    end
  end
  always_comb begin
    fth_d = fth_q;
    feps_d = feps_q;
    wr_en = push && (cnt_q != 3'd4 || pop);
    wr_d = wr_en ? wr_q + 2'd1 : wr_q;
    rd_d = pop ? rd_q + 2'd1 : rd_q;
    cnt_d = cnt_q + 3'(wr_en) - 3'(pop);
    ovf_d = ovf_q || (push && !wr_en);
    if (wr_en) begin
      fth_d[wr_q] = theta_in;
      feps_d[wr_q] = avg;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      ref_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      hist_q <= '{default: '0};
      fth_q <= '{default: '0};
      feps_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q <= ref_d;
      match_q <= match_d;
      miss_q <= miss_d;
      hist_q <= hist_d;
      fth_q <= fth_d;
      feps_q <= feps_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign trk_valid = cnt_q != 3'd0;
  assign trk_theta = trk_valid ? fth_q[rd_q] : '0;
  assign trk_eps = trk_valid ? feps_q[rd_q] : '0;
  assign lock = state_q == LOCKED;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_sync_track.sv
// tb_sync_track: randomized and directed scoreboard bench for sync_track
module tb_sync_track;
  logic clk = 1'b0, rst = 1'b1, est_valid = 1'b0, trk_ready = 1'b0;
  logic [7:0] theta_in = '0;
  logic [11:0] eps_in = '0;
  logic trk_valid, lock, overflow;
  logic [7:0] trk_theta;
  logic [11:0] trk_eps;
  sync_track dut (
    .clk(clk), .rst(rst), .est_valid(est_valid), .theta_in(theta_in), .eps_in(eps_in),
    .trk_ready(trk_ready), .trk_valid(trk_valid), .trk_theta(trk_theta), .trk_eps(trk_eps),
    .lock(lock), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {int th; int ep;} ent_t;
  ent_t exp_q[$];
  int checks = 0, failures = 0;
  bit m_lock, m_ver, m_ovf;
  int m_ref, m_run, m_miss, m_cnt;
  int m_hist[$];
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  function automatic int floor4(int s);
    return s >= 0 ? s / 4 : -((-s + 3) / 4);
  endfunction
  function automatic int hist_at(int i);
    return i < m_hist.size() ? m_hist[i] : 0;
  endfunction
  task automatic model(bit e, int th, int ep, bit rdy, bit r);
    bit pop, do_push, m;
    int d, avg;
    if (r) begin
      m_lock = 0; m_ver = 0; m_ovf = 0; m_ref = 0; m_run = 0; m_miss = 0; m_cnt = 0;
      m_hist.delete();
      exp_q.delete();
      return;
    end
    pop = m_cnt > 0 && rdy;
    do_push = 0;
    avg = 0;
    if (e) begin
      d = ((th - m_ref) % 256 + 256) % 256;
      if (d > 128) d = 256 - d;
      m = d <= 2;
      avg = floor4(ep + hist_at(0) + hist_at(1) + hist_at(2));
      if (m_lock) begin
        if (m) begin
          m_hist.push_front(ep);
          m_ref = th; m_miss = 0; do_push = 1;
        end else begin
          m_miss++;
          if (m_miss == 3) begin m_lock = 0; m_hist.delete(); end
        end
      end else if (m_ver && m) begin
        m_hist.push_front(ep);
        m_ref = th; m_run++;
        if (m_run == 4) begin m_lock = 1; m_ver = 0; m_miss = 0; do_push = 1; end
      end else begin
        m_hist.delete();
        m_hist.push_front(ep);
        m_ref = th; m_run = 1; m_ver = 1;
      end
    end
    if (do_push) begin
      if (m_cnt < 4 || pop) begin
        exp_q.push_back('{th, avg});
        m_cnt++;
      end else m_ovf = 1;
    end
    if (pop) m_cnt--;
  endtask
  task automatic step(bit e, int th, int ep, bit rdy, bit r = 0);
    est_valid = e; theta_in = 8'(th); eps_in = 12'(ep); trk_ready = rdy; rst = r;
    @(posedge clk);
    model(e, th, ep, rdy, r);
    #1;
    chk("lock", lock, m_lock);
    chk("overflow", overflow, m_ovf);
    chk("trk_valid", trk_valid, m_cnt > 0);
    if (!trk_valid) begin
      chk("empty_theta", trk_theta, 0);
      chk("empty_eps", trk_eps, 0);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && trk_valid && trk_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        ent_t x;
        x = exp_q.pop_front();
        chk("trk_theta", trk_theta, x.th);
        chk("trk_eps", $signed(trk_eps), x.ep);
      end
    end
  end
  initial begin
    int base;
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (4) step(1, 100, 40, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 255, 10, 1); step(1, 1, 10, 1); step(1, 3, 10, 1); step(1, 6, 10, 1);
    step(0, 0, 0, 1);
    step(1, 7, 10, 1); step(1, 8, 10, 1); step(1, 9, 10, 1);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (4) step(1, 50, 0, 1);
    step(1, 50, 8, 1); step(1, 50, -8, 1); step(1, 50, 5, 1); step(1, 50, -6, 1);
    step(0, 0, 0, 1);
    step(1, 90, 1, 1); step(1, 90, 1, 1); step(1, 51, 3, 1);
    step(1, 90, 1, 1); step(1, 90, 1, 1); step(1, 90, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (4) step(1, 20, 1, 0);
    repeat (5) step(1, 20, -3, 0);
    step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (4) step(1, 30, 4, 0);
    repeat (2) step(1, 31, 4, 0);
    step(1, 200, 4, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(1, 30, 4, 1);
    step(0, 0, 0, 1);
    step(1, 30, 4, 1);
    repeat (3) step(0, 0, 0, 1);
    base = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 40) == 0) base = $urandom_range(0, 255);
      step($urandom_range(0, 2) != 0, base + $urandom_range(0, 8) - 4,
           $urandom_range(0, 4095) - 2048, $urandom_range(0, 3) != 0,
           $urandom_range(0, 250) == 0);
    end
    repeat (8) step(0, 0, 0, 1);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
